cpu_irq_ctrl: RTL and testbench
===============================

CPU_IRQ_CTRL -- requirements
Module: cpu_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 8, meaning the number of interrupt sources (legal values 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port irq_in, input, NUM_IRQ bits: interrupt sources (e.g. timer irq), level, asynchronous to clk.
REQ-005 The block SHALL have port address, input, 3 bits: Avalon-MM slave register select.
REQ-006 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 The block SHALL have port writedata, input, 16 bits: write data.
REQ-009 The block SHALL have port readdata, output, 16 bits: registered read data.
REQ-010 The block SHALL have port irq, output, 1 bit: registered aggregate interrupt to the CPU.

Function
REQ-011 A write SHALL be chipselect=1 and write_n=0 in one cycle; reads SHALL be zero-wait, with readdata updated every cycle from address (1-cycle latency, no read side effects).
REQ-012 The register map SHALL be:
- 0 PENDING (R; W1C for edge sources)
- 1 MASK (RW)
- 2 EDGE_MODE (RW; 1 = rising-edge, 0 = level)
- 3 ACTIVE (R; PENDING & MASK)
- 4 VECTOR (R)
- 5 RAW (R; synchronized levels)
- 6..7 read 0, writes ignored.
Bits at and above NUM_IRQ SHALL read 0.
REQ-013 Each irq_in bit SHALL pass a 2-flop synchronizer (sync1, sync2), plus a third flop (sync3) holding the previous sync2 value for edge detection.
REQ-014 A level-mode source SHALL have pending[i] <= sync2[i] every cycle; W1C writes SHALL have no effect on it.
REQ-015 An edge-mode source SHALL set pending[i] when sync2[i] & ~sync3[i]; pending[i] SHALL hold until cleared by writing 1 to PENDING bit i.
REQ-016 If set and W1C clear coincide on one bit, set SHALL win.
REQ-017 Latency SHALL be as follows for an irq_in bit high before clk edge k and unmasked:
- sync1 = 1 at edge k
- sync2 = 1 at edge k+1
- pending = 1 at edge k+2
- irq = 1 at edge k+3
REQ-018 The irq output SHALL be the register irq <= |(pending & MASK).
REQ-019 Deasserting a mask bit SHALL drop irq one cycle later and SHALL not clear pending.
REQ-020 VECTOR SHALL read bit15 = |ACTIVE and bits3:0 = index of the lowest-numbered set ACTIVE bit (lowest index = highest priority); bits3:0 SHALL be 0 when none is set.
REQ-021 A write to EDGE_MODE SHALL clear pending bits whose mode bit changes in that write; pending bits whose mode bit is unchanged SHALL be unaffected.
REQ-022 An edge already present on the cycle of a mode change SHALL be lost by design (the clear takes priority over the new mode's set).

Reset
REQ-023 On reset_n=0 the following SHALL clear to 0 immediately, independent of clk: sync1, sync2, sync3, pending, MASK, EDGE_MODE, readdata and irq.
REQ-024 A source already high at reset release SHALL NOT produce an edge-mode event, because sync3 tracks sync2 from 0; it SHALL appear as pending within 2 cycles if level-mode.
REQ-025 Reset asserted mid-operation SHALL discard all pending state; after release, no irq SHALL assert until new source activity or level is synchronized.

Structure
REQ-026 A shared package SHALL hold the register address constants (ADDR_PENDING..ADDR_RAW), the 16-bit data width, and the NUM_IRQ maximum (16).
REQ-027 The synchronizer with edge detect (sync1/sync2/sync3, rise output) SHALL be one sub-module, irq_sync, instantiated once with width NUM_IRQ; priority encode and the register file stay in cpu_irq_ctrl.

Verification
REQ-028 Level source: MASK=0x0001, irq_in[0]=1 -> irq=1 exactly 4 edges later; irq_in[0]=0 -> irq=0 after 4 edges; PENDING reads 0x0000.
REQ-029 Edge source: EDGE_MODE=0x0004, MASK=0x0004, 1-cycle pulse on irq_in[2] -> PENDING=0x0004 and irq=1 held; write PENDING=0x0004 -> irq=0 two cycles later.
REQ-030 Set/clear collision: an edge on bit 2 arrives in the same cycle as the W1C of bit 2 -> PENDING remains 0x0004.
REQ-031 Priority: ACTIVE=0x00A0 -> VECTOR reads 0x8005; with MASK=0 -> VECTOR reads 0x0000 and irq=0.
REQ-032 Masking: pending=0x0001, MASK toggled 1->0->1 -> irq follows with 1-cycle lag; PENDING stays 0x0001 throughout.
REQ-033 Reset mid-operation: with irq=1, pulse reset_n low -> irq, readdata, MASK and PENDING read 0 asynchronously; a source held high through reset in edge mode -> no pending after release.

Source files
------------

// File: rtl/cpu_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_irq_ctrl_pkg : shared constants for the CPU interrupt controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_irq_ctrl_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_IRQ_MAX = 16;

  localparam logic [2:0] ADDR_PENDING   = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR    = 3'd4;
  localparam logic [2:0] ADDR_RAW       = 3'd5;

endpackage

`default_nettype wire

// File: rtl/cpu_irq_ctrl_sync.sv
// ---------------------------------------------------------------------------
// irq_sync : two-flop synchronizer plus a history flop for rising-edge detect
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sync3_q, sync3_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign sync_out = sync2_q;
  assign rise_out = sync2_q & ~sync3_q;

endmodule

`default_nettype wire

// File: rtl/cpu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_irq_ctrl : Avalon-MM interrupt controller with level/edge sources,
//                mask, priority vector and a registered aggregate irq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_irq_ctrl
  import cpu_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq
);

  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] sync_rise;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_mode_q, edge_mode_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic               wr;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] active;
  logic [3:0]         vec_idx;

  irq_sync #(
    .WIDTH (NUM_IRQ)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (irq_in),
    .sync_out (sync_lvl),
    .rise_out (sync_rise)
  );

  if (NUM_IRQ < DATA_W) begin : g_wdata_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[DATA_W-1:NUM_IRQ];
  end

  assign wr     = chipselect & ~write_n;
  assign wdata  = writedata[NUM_IRQ-1:0];
  assign active = pending_q & mask_q;

  always_comb begin
    w1c         = '0;
    mode_chg    = '0;
    mask_d      = mask_q;
    edge_mode_d = edge_mode_q;
    if (wr) begin
      case (address)
        ADDR_PENDING:   w1c = wdata;
        ADDR_MASK:      mask_d = wdata;
        ADDR_EDGE_MODE: begin
          edge_mode_d = wdata;
          mode_chg    = wdata ^ edge_mode_q;
        end
        default: ;
      endcase
    end
  end

  // Edge sources: set beats W1C. A mode change clears the bit and beats both.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_mode_q[i])
        pending_d[i] = sync_rise[i] | (pending_q[i] & ~w1c[i]);
      else
        pending_d[i] = sync_lvl[i];
    end
    pending_d = pending_d & ~mode_chg;
  end

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i])
        vec_idx = 4'(i);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING:   readdata_d = DATA_W'(pending_q);
      ADDR_MASK:      readdata_d = DATA_W'(mask_q);
      ADDR_EDGE_MODE: readdata_d = DATA_W'(edge_mode_q);
      ADDR_ACTIVE:    readdata_d = DATA_W'(active);
      ADDR_VECTOR:    readdata_d = {(|active), 11'd0, vec_idx};
      ADDR_RAW:       readdata_d = DATA_W'(sync_lvl);
      default:        readdata_d = '0;
    endcase
    irq_d = |active;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      mask_q      <= '0;
      edge_mode_q <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_irq_ctrl : table-driven self-checking bench for cpu_irq_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_tests;
  int n_fail;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [7:0]  irq_in;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  cpu_irq_ctrl #(
    .NUM_IRQ (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic [2:0] a, input logic w,
                     input logic [15:0] wd, input logic [7:0] src,
                     input logic crd, input logic [15:0] erd,
                     input logic cirq, input logic eirq);
    vec_t v;
    v.name = name; v.addr = a; v.wr = w; v.wdata = wd; v.irq_in = src;
    v.chk_rd = crd; v.exp_rd = erd; v.chk_irq = cirq; v.exp_irq = eirq;
    vecs.push_back(v);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic [2:0] a, input logic w, input logic [15:0] wd,
                      input logic [7:0] src);
    @(negedge clk);
    address    = a;
    chipselect = w;
    write_n    = ~w;
    writedata  = wd;
    irq_in     = src;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b1;
    irq_in     = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Level source bit 0
    add("mask_wr",   3'd1, 1, 16'h0001, 8'h00, 1, 16'h0000, 1, 0);
    add("mask_rd",   3'd1, 0, 16'h0000, 8'h00, 1, 16'h0001, 1, 0);
    add("lvl_k",     3'd5, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 0);
    add("lvl_k1",    3'd5, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 0);
    add("lvl_k2",    3'd5, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 0);
    add("lvl_k3",    3'd5, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("lvl_off0",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0001, 1, 1);
    add("lvl_off1",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0001, 1, 1);
    add("lvl_off2",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0001, 1, 1);
    add("lvl_off3",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    // Edge source bit 2
    add("em_wr",     3'd2, 1, 16'h0004, 8'h00, 1, 16'h0000, 1, 0);
    add("emask_wr",  3'd1, 1, 16'h0004, 8'h00, 1, 16'h0001, 1, 0);
    add("edg_k",     3'd0, 0, 16'h0000, 8'h04, 1, 16'h0000, 1, 0);
    add("edg_k1",    3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    add("edg_k2",    3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    add("edg_k3",    3'd0, 0, 16'h0000, 8'h00, 1, 16'h0004, 1, 1);
    add("edg_hold",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0004, 1, 1);
    add("w1c",       3'd0, 1, 16'h0004, 8'h00, 1, 16'h0004, 1, 1);
    add("w1c_1",     3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    // Set/clear collision on bit 2
    add("col_k",     3'd0, 0, 16'h0000, 8'h04, 1, 16'h0000, 1, 0);
    add("col_k1",    3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    add("col_w1c",   3'd0, 1, 16'h0004, 8'h00, 1, 16'h0000, 1, 0);
    add("col_hold",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0004, 1, 1);
    add("col_clr",   3'd0, 1, 16'h0004, 8'h00, 1, 16'h0004, 1, 1);
    add("col_clr1",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    // Priority vector
    add("pri_wr",    3'd1, 1, 16'h00A0, 8'hA0, 1, 16'h0004, 1, 0);
    add("pri_k1",    3'd4, 0, 16'h0000, 8'hA0, 1, 16'h0000, 1, 0);
    add("pri_k2",    3'd4, 0, 16'h0000, 8'hA0, 1, 16'h0000, 1, 0);
    add("pri_vec",   3'd4, 0, 16'h0000, 8'hA0, 1, 16'h8005, 1, 1);
    add("pri_act",   3'd3, 0, 16'h0000, 8'hA0, 1, 16'h00A0, 1, 1);
    add("pri_m0",    3'd1, 1, 16'h0000, 8'hA0, 1, 16'h00A0, 1, 1);
    add("pri_vec0",  3'd4, 0, 16'h0000, 8'hA0, 1, 16'h0000, 1, 0);
    add("pri_off0",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h00A0, 1, 0);
    add("pri_off1",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h00A0, 1, 0);
    add("pri_off2",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h00A0, 1, 0);
    add("pri_off3",  3'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 1, 0);
    // Mask toggling with bit 0 pending
    add("msk_on",    3'd1, 1, 16'h0001, 8'h01, 1, 16'h0000, 1, 0);
    add("msk_k1",    3'd0, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 0);
    add("msk_k2",    3'd0, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 0);
    add("msk_k3",    3'd0, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("msk_off",   3'd1, 1, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("msk_lag",   3'd0, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 0);
    add("msk_on2",   3'd1, 1, 16'h0001, 8'h01, 1, 16'h0000, 1, 0);
    add("msk_lag2",  3'd0, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("msk_all",   3'd1, 1, 16'hFFFF, 8'h01, 1, 16'h0001, 1, 1);
    add("msk_rdall", 3'd1, 0, 16'h0000, 8'h01, 1, 16'h00FF, 1, 1);
    add("a6_wr",     3'd6, 1, 16'hFFFF, 8'h01, 1, 16'h0000, 1, 1);
    add("a7_rd",     3'd7, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 1);
    add("a6_rd",     3'd6, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 1);
    add("raw_rd",    3'd5, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    // Mode change clears only the bits that flip
    add("p2_k",      3'd0, 0, 16'h0000, 8'h05, 1, 16'h0001, 1, 1);
    add("p2_k1",     3'd0, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("p2_k2",     3'd0, 0, 16'h0000, 8'h01, 1, 16'h0001, 1, 1);
    add("mode_chg",  3'd2, 1, 16'h0005, 8'h01, 1, 16'h0004, 1, 1);
    add("mode_clr",  3'd0, 0, 16'h0000, 8'h01, 1, 16'h0004, 1, 1);
    add("mode_hold", 3'd0, 0, 16'h0000, 8'h01, 1, 16'h0004, 1, 1);
    add("mode_w1c",  3'd0, 1, 16'h0004, 8'h01, 1, 16'h0004, 1, 1);
    add("mode_w1c1", 3'd0, 0, 16'h0000, 8'h01, 1, 16'h0000, 1, 0);

    // Power-on reset
    #2 reset_n = 1'b0;
    #1;
    chk16("por_rd", readdata, 16'h0000);
    chk16("por_irq", {15'd0, irq}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].irq_in);
      if (vecs[i].chk_rd)
        chk16({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
      if (vecs[i].chk_irq)
        chk16({vecs[i].name, "_irq"}, {15'd0, irq}, {15'd0, vecs[i].exp_irq});
    end

    // Mid-operation reset: bring bit 0 back to level mode so irq asserts
    step(3'd2, 1'b1, 16'h0000, 8'h01);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    chk16("pre_rst_irq", {15'd0, irq}, 16'h0001);
    chk16("pre_rst_rd", readdata, 16'h0001);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk16("async_irq", {15'd0, irq}, 16'h0000);
    chk16("async_rd", readdata, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    step(3'd1, 1'b0, 16'h0000, 8'h01);
    chk16("rst_mask_rd", readdata, 16'h0000);
    chk16("rst_irq0", {15'd0, irq}, 16'h0000);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    chk16("rst_pend0", readdata, 16'h0000);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    step(3'd0, 1'b0, 16'h0000, 8'h01);
    chk16("rst_lvl_pend", readdata, 16'h0001);
    chk16("rst_irq1", {15'd0, irq}, 16'h0000);
    // Switch to edge mode with the source still high: no edge is ever seen
    step(3'd2, 1'b1, 16'h0001, 8'h01);
    for (int k = 0; k < 4; k++) begin
      step(3'd0, 1'b0, 16'h0000, 8'h01);
      chk16("rst_edge_nopend", readdata, 16'h0000);
    end
    chk16("rst_edge_irq", {15'd0, irq}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
